bus_rx_endpoint: RTL and testbench
==================================

Name: bus_rx_endpoint

Overview:
- Device-side receiver for one port of the bus generator/arbiter (bs_gnrtr_n_rbtr).
- The bus delivers packets to this port with the push / D_push signals. The transmitter side of the same port presents packets on pndng / D_pop and is popped by the bus.
- The block filters packets by destination ID, buffers accepted packets in a first-word-fall-through FIFO, and presents them to a local consumer over a valid/ready handshake.
- It also counts misaddressed packets and overflow drops, because the bus push path has no backpressure.

Parameters:
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1:pckg_sz-8] hold the destination ID, bits [pckg_sz-9:0] hold the payload.
- deep_fifo, 8, receive FIFO depth in packets; any value ≥ 2, not restricted to powers of two.
- id, 0, this port's 8-bit address.
- bdcst, 8'hFF, broadcast address; every endpoint accepts packets carrying it.
- cnt_w, 8, width of the saturating statistics counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- push  input  1  bus strobe: D_push holds a valid packet this cycle.
- D_push  input  pckg_sz  packet delivered by the bus.
- rx_valid  output  1  the FIFO head is available on rx_data.
- rx_data  output  pckg_sz  FIFO head packet, full width, ID not stripped.
- rx_ready  input  1  consumer accepts the head this cycle.
- full  output  1  FIFO holds deep_fifo packets.
- count  output  $clog2(deep_fifo+1)  current FIFO occupancy.
- misaddr_cnt  output  cnt_w  packets ignored because of a destination mismatch; saturating.
- ovf_cnt  output  cnt_w  addressed packets dropped because the FIFO was full; saturating.
- ovf  output  1  sticky overflow flag.

Behaviour:
- Reset values, asserted asynchronously:
  - rx_valid=0, rx_data=0, full=0, count=0, misaddr_cnt=0, ovf_cnt=0, ovf=0.
  - Read and write pointers are zero; FIFO contents are don't-care.
- Address match: match = (D_push[pckg_sz-1:pckg_sz-8]==id) || (D_push[pckg_sz-1:pckg_sz-8]==bdcst).
- Pop condition: pop = rx_valid && rx_ready. rx_ready while rx_valid=0 has no effect.
- Write condition: wr = push && match && (!full || pop).
  - A push into a full FIFO is accepted if a pop happens in the same cycle; count is then unchanged.
- Overflow: push && match && full && !pop drops the packet.
  - ovf_cnt increments, saturating at 2^cnt_w-1.
  - ovf is set and stays 1 until reset.
- Misaddress: push && !match leaves the FIFO untouched and increments misaddr_cnt, saturating.
- Pointers:
  - The write pointer advances on wr and the read pointer on pop.
  - Each wraps from deep_fifo-1 to 0.
- Occupancy:
  - count increments on wr&&!pop, decrements on pop&&!wr, and holds otherwise.
  - full=(count==deep_fifo); rx_valid=(count!=0). Both are derived from registered count, so there are no combinational paths from the inputs.
- Latency and head presentation:
  - A packet pushed in cycle N is visible as rx_valid=1 with rx_data=packet in cycle N+1 when the FIFO was empty.
  - rx_data always shows mem[rd_ptr].
  - rx_data holds its value while rx_valid && !rx_ready.
- Simultaneous push and pop on an empty FIFO is impossible, since pop requires rx_valid.
  - A push into a FIFO holding one packet while that packet is popped leaves count=1, and the new packet becomes the head next cycle.
- Ordering: accepted packets leave in arrival order. No packet is duplicated or reordered.
- Reset mid-operation: all buffered packets are discarded; outputs return to their reset values immediately.

Test Plan:
- Basic receive: id=1, push D_push=16'h0102 for one cycle, rx_ready=0 → next cycle rx_valid=1, rx_data=16'h0102, count=1; raise rx_ready for 1 cycle → rx_valid=0, count=0.
- Filtering: id=1, push 16'h0205 then 16'hFF07 → only 16'hFF07 is buffered, misaddr_cnt=1, count=1.
- Fill and overflow:
  - Stimulus: deep_fifo=8, rx_ready=0, push 10 addressed packets 16'h0100..16'h0109.
  - Response: full=1, count=8, ovf_cnt=2, ovf=1.
  - Draining returns 16'h0100..16'h0107 in order, then full=0.
- Full with simultaneous pop: on a full FIFO, push 16'h01AA with rx_ready=1 in the same cycle → count stays 8, ovf_cnt unchanged, 16'h01AA is the last packet drained.
- Wrap-around: 20 back-to-back pushes with rx_ready=1 continuously → all 20 packets come out in order, count never exceeds 1, no drops.
- Reset mid-operation: with count=5, ovf=1 and misaddr_cnt=3, assert reset between clock edges → all outputs go to zero immediately; after release, one push of 16'h0133 gives rx_data=16'h0133.

Source files
------------

// File: rtl/bus_rx_endpoint.sv
// Bus receive endpoint: destination-ID filter, first-word-fall-through receive
// FIFO with a valid/ready consumer port, and saturating drop statistics.
module bus_rx_endpoint #(
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned deep_fifo = 8,
  parameter logic [7:0]  id        = 8'h00,
  parameter logic [7:0]  bdcst     = 8'hFF,
  parameter int unsigned cnt_w     = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [pckg_sz-1:0]             D_push,
  output logic                           rx_valid,
  output logic [pckg_sz-1:0]             rx_data,
  input  logic                           rx_ready,
  output logic                           full,
  output logic [$clog2(deep_fifo+1)-1:0] count,
  output logic [cnt_w-1:0]               misaddr_cnt,
  output logic [cnt_w-1:0]               ovf_cnt,
  output logic                           ovf
);

  localparam int unsigned PTR_W = (deep_fifo > 1) ? $clog2(deep_fifo) : 1;
  localparam int unsigned OCC_W = $clog2(deep_fifo + 1);

  logic [pckg_sz-1:0] r_mem [deep_fifo];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [OCC_W-1:0]   r_count;
  logic               r_full;
  logic               r_valid;
  logic [cnt_w-1:0]   r_misaddr_cnt;
  logic [cnt_w-1:0]   r_ovf_cnt;
  logic               r_ovf;

  logic               w_match;
  logic               w_pop;
  logic               w_wr;
  logic               w_drop;
  logic               w_misaddr;
  logic [OCC_W-1:0]   w_count_nxt;

  // Pointer advance with wrap at deep_fifo-1 (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(deep_fifo - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Transfer qualification and next occupancy.
  always_comb begin
    w_match     = 1'b0;
    w_pop       = 1'b0;
    w_wr        = 1'b0;
    w_drop      = 1'b0;
    w_misaddr   = 1'b0;
    w_count_nxt = r_count;

    w_match   = (D_push[pckg_sz-1 -: 8] == id) || (D_push[pckg_sz-1 -: 8] == bdcst);
    w_pop     = r_valid && rx_ready;
    w_wr      = push && w_match && (!r_full || w_pop);
    w_drop    = push && w_match && r_full && !w_pop;
    w_misaddr = push && !w_match;

    if (w_wr && !w_pop) begin
      w_count_nxt = r_count + OCC_W'(1);
    end else if (w_pop && !w_wr) begin
      w_count_nxt = r_count - OCC_W'(1);
    end
  end

  // Packet storage; cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(deep_fifo); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= D_push;
    end
  end

  // Pointers, occupancy and status flags registered from the next occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == OCC_W'(deep_fifo));
      r_valid <= (w_count_nxt != '0);
    end
  end

  // Saturating statistics and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misaddr_cnt <= '0;
      r_ovf_cnt     <= '0;
      r_ovf         <= 1'b0;
    end else begin
      if (w_misaddr && (r_misaddr_cnt != '1)) begin
        r_misaddr_cnt <= r_misaddr_cnt + cnt_w'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_ovf_cnt != '1) begin
          r_ovf_cnt <= r_ovf_cnt + cnt_w'(1);
        end
      end
    end
  end

  assign rx_valid    = r_valid;
  assign rx_data     = r_mem[r_rd_ptr];
  assign full        = r_full;
  assign count       = r_count;
  assign misaddr_cnt = r_misaddr_cnt;
  assign ovf_cnt     = r_ovf_cnt;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_bus_rx_endpoint.sv
// Directed testbench for bus_rx_endpoint (id=1, depth 8, 16-bit packets).
module tb_bus_rx_endpoint;

  logic        clk;
  logic        reset;
  logic        push;
  logic [15:0] D_push;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_ready;
  logic        full;
  logic [3:0]  count;
  logic [7:0]  misaddr_cnt;
  logic [7:0]  ovf_cnt;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  bus_rx_endpoint #(
    .pckg_sz  (16),
    .deep_fifo(8),
    .id       (8'h01),
    .bdcst    (8'hFF),
    .cnt_w    (8)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .D_push     (D_push),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .full       (full),
    .count      (count),
    .misaddr_cnt(misaddr_cnt),
    .ovf_cnt    (ovf_cnt),
    .ovf        (ovf)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs settle 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [15:0] pkt);
    push   = 1'b1;
    D_push = pkt;
    tick();
    push   = 1'b0;
    D_push = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},   32'(rx_valid),    32'd0);
    check({tag, "_data"},    32'(rx_data),     32'd0);
    check({tag, "_full"},    32'(full),        32'd0);
    check({tag, "_count"},   32'(count),       32'd0);
    check({tag, "_misaddr"}, 32'(misaddr_cnt), 32'd0);
    check({tag, "_ovfcnt"},  32'(ovf_cnt),     32'd0);
    check({tag, "_ovf"},     32'(ovf),         32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    push     = 1'b0;
    D_push   = '0;
    rx_ready = 1'b0;
    tick();
    tick();
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b0;

    // Basic receive and single pop.
    push_one(16'h0102);
    check("basic_valid", 32'(rx_valid), 32'd1);
    check("basic_data",  32'(rx_data),  32'h0102);
    check("basic_count", 32'(count),    32'd1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("basic_pop_valid", 32'(rx_valid), 32'd0);
    check("basic_pop_count", 32'(count),    32'd0);

    // Destination filtering: wrong ID dropped, broadcast accepted.
    push_one(16'h0205);
    push_one(16'hFF07);
    check("filt_misaddr", 32'(misaddr_cnt), 32'd1);
    check("filt_count",   32'(count),       32'd1);
    check("filt_data",    32'(rx_data),     32'hFF07);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("filt_drain", 32'(count), 32'd0);

    // Fill past capacity, then drain in order.
    for (int i = 0; i < 10; i++) push_one(16'h0100 + 16'(i));
    check("fill_full",   32'(full),    32'd1);
    check("fill_count",  32'(count),   32'd8);
    check("fill_ovfcnt", 32'(ovf_cnt), 32'd2);
    check("fill_ovf",    32'(ovf),     32'd1);
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), 32'(rx_data), 32'h0100 + 32'(i));
      tick();
    end
    rx_ready = 1'b0;
    check("drain_full",  32'(full),  32'd0);
    check("drain_count", 32'(count), 32'd0);

    // Push into a full FIFO with a simultaneous pop.
    for (int i = 0; i < 8; i++) push_one(16'h0100 + 16'(i));
    check("refill_full", 32'(full), 32'd1);
    push     = 1'b1;
    D_push   = 16'h01AA;
    rx_ready = 1'b1;
    tick();
    push     = 1'b0;
    D_push   = '0;
    rx_ready = 1'b0;
    check("fp_count",  32'(count),   32'd8);
    check("fp_ovfcnt", 32'(ovf_cnt), 32'd2);
    rx_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check($sformatf("fp_drain_%0d", i), 32'(rx_data), 32'h0100 + 32'(i));
      tick();
    end
    check("fp_last", 32'(rx_data), 32'h01AA);
    tick();
    rx_ready = 1'b0;
    check("fp_empty", 32'(count), 32'd0);

    // Back-to-back pushes with a consumer that is always ready.
    rx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push   = 1'b1;
      D_push = 16'h0140 + 16'(i);
      tick();
      check($sformatf("wrap_data_%0d", i),  32'(rx_data), 32'h0140 + 32'(i));
      check($sformatf("wrap_count_%0d", i), 32'(count),   32'd1);
    end
    push   = 1'b0;
    D_push = '0;
    tick();
    rx_ready = 1'b0;
    check("wrap_empty",  32'(count),   32'd0);
    check("wrap_ovfcnt", 32'(ovf_cnt), 32'd2);

    // Build up state, then reset asynchronously between clock edges.
    push_one(16'h0305);
    push_one(16'h0405);
    for (int i = 0; i < 5; i++) push_one(16'h0160 + 16'(i));
    check("pre_count",   32'(count),       32'd5);
    check("pre_misaddr", 32'(misaddr_cnt), 32'd3);
    check("pre_ovf",     32'(ovf),         32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("arst");
    @(negedge clk);
    reset = 1'b0;
    push_one(16'h0133);
    check("post_valid", 32'(rx_valid), 32'd1);
    check("post_data",  32'(rx_data),  32'h0133);
    check("post_count", 32'(count),    32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
